// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: opcodes, ALU ops, sequencer states, beat indices,
// and the packed control-strobe bundle passed from the decoder to the sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_JMP = 4'h5,
        OP_JZ  = 4'h6,
        OP_JC  = 4'h7,
        OP_OUT = 4'h8,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        B_T0 = 3'd0,
        B_T1 = 3'd1,
        B_T2 = 3'd2,
        B_T3 = 3'd3,
        B_T4 = 3'd4,
        B_T5 = 3'd5
    } beat_e;

    // Previous-beat reset value: t5, so the first legal beat after reset is t0.
    localparam logic [5:0] BEAT_RESET = 6'b100000;

    typedef struct packed {
        logic    mar_load;
        logic    mar_src;
        logic    mem_rd;
        logic    mem_wr;
        logic    ir_load;
        logic    pc_inc;
        logic    pc_load;
        logic    b_load;
        logic    acc_load;
        logic    flags_load;
        logic    out_load;
        alu_op_e alu_op;
        logic    halt_req;
    } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational decoder: opcode, beat index and flags to the raw (ungated) control strobes.
module ctrl_decode
    import cpu_pkg::*;
(
    input  opcode_e op_i,
    input  beat_e   beat_i,
    input  logic    zf_i,
    input  logic    cf_i,
    output ctrl_t   ctrl_o
);

    logic mem_ref;

    assign mem_ref = (op_i == OP_LDA) || (op_i == OP_ADD) ||
                     (op_i == OP_SUB) || (op_i == OP_STA);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ALU_PASS;
        unique case (beat_i)
            B_T0: ctrl_o.mar_load = 1'b1;
            B_T1: begin
                ctrl_o.mem_rd  = 1'b1;
                ctrl_o.ir_load = 1'b1;
                ctrl_o.pc_inc  = 1'b1;
            end
            B_T2: begin
                ctrl_o.mar_load = mem_ref;
                ctrl_o.mar_src  = mem_ref;
                ctrl_o.pc_load  = (op_i == OP_JMP) ||
                                  ((op_i == OP_JZ) && zf_i) ||
                                  ((op_i == OP_JC) && cf_i);
                ctrl_o.out_load = (op_i == OP_OUT);
                ctrl_o.halt_req = (op_i == OP_HLT);
            end
            B_T3: begin
                ctrl_o.mem_rd   = (op_i == OP_LDA) || (op_i == OP_ADD) || (op_i == OP_SUB);
                ctrl_o.acc_load = (op_i == OP_LDA);
                ctrl_o.b_load   = (op_i == OP_ADD) || (op_i == OP_SUB);
                ctrl_o.mem_wr   = (op_i == OP_STA);
            end
            B_T4: begin
                if (op_i == OP_ADD || op_i == OP_SUB) begin
                    ctrl_o.acc_load   = 1'b1;
                    ctrl_o.flags_load = 1'b1;
                    ctrl_o.alu_op     = (op_i == OP_ADD) ? ALU_ADD : ALU_SUB;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Hardwired control sequencer: run/halt FSM, instruction register, beat-integrity checker,
// and gating of the decoded strobes onto the datapath.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned OPW = 4,
    parameter int unsigned ADW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               t0,
    input  logic               t1,
    input  logic               t2,
    input  logic               t3,
    input  logic               t4,
    input  logic               t5,
    input  logic               run,
    input  logic [OPW+ADW-1:0] mem_dout,
    input  logic               zf,
    input  logic               cf,
    output logic               mar_load,
    output logic               mar_src,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               b_load,
    output logic               acc_load,
    output logic               flags_load,
    output logic               out_load,
    output logic [2:0]         alu_op,
    output logic [ADW-1:0]     operand,
    output logic [1:0]         state_o,
    output logic               halted,
    output logic               beat_err
);

    localparam int unsigned IW = OPW + ADW;

    state_e          state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [5:0]      prev_q;
    logic            armed_q, armed_d;
    logic            beat_err_q, beat_err_d;
    logic [5:0]      beat;
    logic            bad;
    logic            en;
    beat_e           idx;
    ctrl_t           dec, ctl;

    assign beat = {t5, t4, t3, t2, t1, t0};
    // The expected beat is one-hot, so equality also covers the one-hot check.
    assign bad  = (beat != {prev_q[4:0], prev_q[5]});

    always_comb begin
        idx = B_T0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (beat[i]) idx = beat_e'(i[2:0]);
        end
    end

    ctrl_decode u_decode (
        .op_i   (opcode_e'(ir_q[IW-1 -: OPW])),
        .beat_i (idx),
        .zf_i   (zf),
        .cf_i   (cf),
        .ctrl_o (dec)
    );

    // RUN is entered on a t0 edge; strobes wait until the next t0 so fetch starts cleanly.
    assign en  = (state_q == S_RUN) && (armed_q || t0) && !bad && !beat_err_q;
    assign ctl = en ? dec : '0;

    assign mar_load   = ctl.mar_load;
    assign mar_src    = ctl.mar_src;
    assign mem_rd     = ctl.mem_rd;
    assign mem_wr     = ctl.mem_wr;
    assign ir_load    = ctl.ir_load;
    assign pc_inc     = ctl.pc_inc;
    assign pc_load    = ctl.pc_load;
    assign b_load     = ctl.b_load;
    assign acc_load   = ctl.acc_load;
    assign flags_load = ctl.flags_load;
    assign out_load   = ctl.out_load;
    assign alu_op     = ctl.alu_op;
    assign operand    = ir_q[ADW-1:0];
    assign state_o    = state_q;
    assign halted     = (state_q == S_HALT);
    assign beat_err   = beat_err_q;

    always_comb begin
        state_d    = state_q;
        ir_d       = ctl.ir_load ? mem_dout : ir_q;
        beat_err_d = beat_err_q | bad;
        if (bad) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (t0 && run && !beat_err_q) state_d = S_RUN;
                S_RUN:   if (ctl.halt_req) state_d = S_HALT;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
        armed_d = (state_d == S_RUN) && (armed_q || ((state_q == S_RUN) && t0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            prev_q     <= BEAT_RESET;
            armed_q    <= 1'b0;
            beat_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            prev_q     <= beat;
            armed_q    <= armed_d;
            beat_err_q <= beat_err_d;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: table of single-instruction rotations plus hand sequences
// for start-up, halt, reset during STA, and beat-integrity errors.
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] tvec;
    logic       run;
    logic [7:0] mem_dout;
    logic       zf, cf;
    logic       mar_load, mar_src, mem_rd, mem_wr, ir_load, pc_inc, pc_load;
    logic       b_load, acc_load, flags_load, out_load;
    logic [2:0] alu_op;
    logic [3:0] operand;
    logic [1:0] state_o;
    logic       halted, beat_err;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cpu_ctrl #(.OPW(4), .ADW(4)) dut (
        .clk(clk), .rst(rst),
        .t0(tvec[0]), .t1(tvec[1]), .t2(tvec[2]), .t3(tvec[3]), .t4(tvec[4]), .t5(tvec[5]),
        .run(run), .mem_dout(mem_dout), .zf(zf), .cf(cf),
        .mar_load(mar_load), .mar_src(mar_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .b_load(b_load),
        .acc_load(acc_load), .flags_load(flags_load), .out_load(out_load),
        .alu_op(alu_op), .operand(operand), .state_o(state_o), .halted(halted),
        .beat_err(beat_err)
    );

    // Strobe word order: mar_load mar_src mem_rd mem_wr ir_load pc_inc pc_load
    //                    b_load acc_load flags_load out_load alu_op[2:0]
    localparam logic [13:0] K_MAR   = 14'h2000;
    localparam logic [13:0] K_SRC   = 14'h1000;
    localparam logic [13:0] K_RD    = 14'h0800;
    localparam logic [13:0] K_WR    = 14'h0400;
    localparam logic [13:0] K_IR    = 14'h0200;
    localparam logic [13:0] K_PCI   = 14'h0100;
    localparam logic [13:0] K_PCL   = 14'h0080;
    localparam logic [13:0] K_B     = 14'h0040;
    localparam logic [13:0] K_ACC   = 14'h0020;
    localparam logic [13:0] K_FLG   = 14'h0010;
    localparam logic [13:0] K_OUT   = 14'h0008;
    localparam logic [13:0] K_ADD   = 14'h0001;
    localparam logic [13:0] K_SUB   = 14'h0002;
    localparam logic [13:0] K_FETCH0 = K_MAR;
    localparam logic [13:0] K_FETCH1 = K_RD | K_IR | K_PCI;

    typedef struct {
        logic [7:0]  instr;
        logic        zf;
        logic        cf;
        logic [13:0] e2, e3, e4, e5;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [13:0] strobes();
        return {mar_load, mar_src, mem_rd, mem_wr, ir_load, pc_inc, pc_load,
                b_load, acc_load, flags_load, out_load, alu_op};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step_raw(input logic [5:0] v);
        @(posedge clk);
        #1 tvec = v;
        @(negedge clk);
    endtask

    task automatic step(input int idx);
        step_raw(6'(1 << idx));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tvec = 6'b000001;
        run  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // From mid-t0 in IDLE: start, then sit through the wait rotation ending at t5.
    task automatic start_run();
        run = 1'b1;
        step(1);
        run = 1'b0;
        for (int b = 2; b < 6; b++) step(b);
    endtask

    initial begin
        zf = 1'b0; cf = 1'b0; mem_dout = 8'h00;
        tbl[0]  = '{8'h1A, 1'b0, 1'b0, K_MAR | K_SRC, K_RD | K_ACC, 14'h0, 14'h0};
        tbl[1]  = '{8'h2B, 1'b0, 1'b0, K_MAR | K_SRC, K_RD | K_B, K_ACC | K_FLG | K_ADD, 14'h0};
        tbl[2]  = '{8'h3C, 1'b0, 1'b0, K_MAR | K_SRC, K_RD | K_B, K_ACC | K_FLG | K_SUB, 14'h0};
        tbl[3]  = '{8'h4C, 1'b0, 1'b0, K_MAR | K_SRC, K_WR, 14'h0, 14'h0};
        tbl[4]  = '{8'h55, 1'b0, 1'b0, K_PCL, 14'h0, 14'h0, 14'h0};
        tbl[5]  = '{8'h65, 1'b1, 1'b0, K_PCL, 14'h0, 14'h0, 14'h0};
        tbl[6]  = '{8'h65, 1'b0, 1'b1, 14'h0, 14'h0, 14'h0, 14'h0};
        tbl[7]  = '{8'h73, 1'b0, 1'b1, K_PCL, 14'h0, 14'h0, 14'h0};
        tbl[8]  = '{8'h73, 1'b1, 1'b0, 14'h0, 14'h0, 14'h0, 14'h0};
        tbl[9]  = '{8'h87, 1'b0, 1'b0, K_OUT, 14'h0, 14'h0, 14'h0};
        tbl[10] = '{8'h00, 1'b0, 1'b0, 14'h0, 14'h0, 14'h0, 14'h0};
        tbl[11] = '{8'h9A, 1'b1, 1'b1, 14'h0, 14'h0, 14'h0, 14'h0};

        // Reset state, then run raised in t3 while IDLE.
        do_reset();
        chk("rst_state", state_o, 2'd0);
        chk("rst_strobes", strobes(), 14'h0);
        chk("rst_operand", operand, 4'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_beat_err", beat_err, 1'b0);
        step(1); step(2); step(3);
        run = 1'b1;
        for (int b = 3; b < 7; b++) begin
            if (b > 3) step(b % 6);
            chk("idle_wait_state", state_o, 2'd0);
            chk("idle_wait_strobes", strobes(), 14'h0);
        end
        step(1);
        run = 1'b0;
        chk("enter_run_state", state_o, 2'd1);
        chk("wait_rot_t1", strobes(), 14'h0);
        for (int b = 2; b < 6; b++) begin
            step(b);
            chk("wait_rot_strobes", strobes(), 14'h0);
        end

        // One instruction per full rotation.
        for (int i = 0; i < 12; i++) begin
            zf = tbl[i].zf;
            cf = tbl[i].cf;
            step(0);
            chk("fetch_t0", strobes(), K_FETCH0);
            mem_dout = tbl[i].instr;
            step(1);
            chk("fetch_t1", strobes(), K_FETCH1);
            step(2);
            chk("exec_t2", strobes(), tbl[i].e2);
            chk("operand", operand, tbl[i].instr[3:0]);
            chk("run_state", state_o, 2'd1);
            step(3);
            chk("exec_t3", strobes(), tbl[i].e3);
            step(4);
            chk("exec_t4", strobes(), tbl[i].e4);
            step(5);
            chk("exec_t5", strobes(), tbl[i].e5);
        end

        // HLT: halted after the edge ending t2, no fetch afterwards.
        step(0);
        mem_dout = 8'hF0;
        step(1);
        step(2);
        chk("hlt_t2_strobes", strobes(), 14'h0);
        chk("hlt_t2_state", state_o, 2'd1);
        step(3);
        chk("halt_state", state_o, 2'd2);
        chk("halt_flag", halted, 1'b1);
        step(4); step(5); step(0);
        chk("halt_no_fetch", strobes(), 14'h0);
        chk("halt_sticky", state_o, 2'd2);

        // Reset asserted during t3 of STA.
        do_reset();
        start_run();
        step(0);
        mem_dout = 8'h4C;
        step(1);
        step(2);
        step(3);
        chk("sta_t3_wr", mem_wr, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_wr", mem_wr, 1'b0);
        chk("rst_mid_state", state_o, 2'd0);
        chk("rst_mid_ir", operand, 4'h0);
        chk("rst_mid_strobes", strobes(), 14'h0);

        // Illegal beat pattern mid-instruction.
        do_reset();
        start_run();
        step(0);
        chk("err_pre_fetch", strobes(), K_FETCH0);
        mem_dout = 8'h1A;
        step(1);
        step_raw(6'b000011);
        chk("err_cycle_strobes", strobes(), 14'h0);
        chk("err_cycle_flag", beat_err, 1'b0);
        step(3);
        chk("err_flag_set", beat_err, 1'b1);
        chk("err_state_idle", state_o, 2'd0);
        chk("err_strobes", strobes(), 14'h0);
        run = 1'b1;
        step(4); step(5); step(0); step(1);
        chk("err_flag_sticky", beat_err, 1'b1);
        chk("err_no_restart", state_o, 2'd0);
        chk("err_strobes_later", strobes(), 14'h0);
        run = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
